amax_bmin_pipe: RTL

AMAX_BMIN_PIPE -- requirements
Module: amax_bmin_pipe

---
 rtl/boid_xcel_pkg.sv | 15 +
 rtl/fix_abs_sat.sv | 27 ++
 rtl/amax_bmin_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/boid_xcel_pkg.sv
// Shared types and constants for the boid accelerator datapath blocks.
package boid_xcel_pkg;

    // Alpha-max/beta-min coefficient selection carried with each beat.
    typedef enum logic [1:0] {
        AMB_HALF    = 2'd0,  // M + m/2
        AMB_QUARTER = 2'd1,  // M + m/4
        AMB_15_16   = 2'd2,  // 15/16 M + 15/32 m
        AMB_MAX78   = 2'd3   // max(M, 7/8 M + m/2)
    } amb_mode_e;

    // Register stages between input acceptance and the output port.
    localparam int unsigned AMB_STAGES = 3;

endpackage : boid_xcel_pkg

// File: rtl/fix_abs_sat.sv
// Absolute value of a signed word; the most-negative input clamps to the
// largest positive magnitude and raises sat_c.
module fix_abs_sat #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-2:0] mag_c,
    output logic             sat_c
);

    localparam int unsigned MW = WIDTH - 1;

    // Negation only needs the low MW bits: the result always fits below the sign.
    always_comb begin
        mag_c = x[MW-1:0];
        sat_c = 1'b0;
        if (x[WIDTH-1]) begin
            if (x[MW-1:0] == '0) begin
                mag_c = '1;
                sat_c = 1'b1;
            end else begin
                mag_c = ~x[MW-1:0] + MW'(1);
            end
        end
    end

endmodule : fix_abs_sat

// File: rtl/amax_bmin_pipe.sv
// Three-stage alpha-max/beta-min magnitude estimator with speed-limit flags.
// S1 registers |a|,|b|; S2 registers max/min; S3 registers the combined,
// saturated magnitude and limit compares and drives the output port.
module amax_bmin_pipe
    import boid_xcel_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 15,
    parameter int unsigned TAG_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_mode,
    input  logic [WIDTH-2:0]   in_lim_lo,
    input  logic [WIDTH-2:0]   in_lim_hi,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_mag,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_slow,
    output logic               out_fast,
    output logic               out_sat
);

    localparam int unsigned MW = WIDTH - 1;   // magnitude bits (sign always 0)
    localparam int unsigned SW = WIDTH + 1;   // combine arithmetic width
    localparam logic [MW-1:0] MAG_MAX = '1;

    // FRAC only sets the binary point; it must leave room for the sign bit.
    if (FRAC >= WIDTH) begin : g_frac_chk
        $error("amax_bmin_pipe: FRAC must be smaller than WIDTH");
    end

    // ---------------------------------------------------------------- flow
    logic s1_valid, s2_valid;
    logic s1_en, s2_en, s3_en;

    // A stage loads when it is empty or its contents move downstream.
    assign s3_en    = !out_valid || out_ready;
    assign s2_en    = !s2_valid  || s3_en;
    assign s1_en    = !s1_valid  || s2_en;
    assign in_ready = reset && s1_en;

    // ---------------------------------------------------------------- S1
    logic [MW-1:0]    abs_a_c, abs_b_c;
    logic             sat_a_c, sat_b_c;
    logic [MW-1:0]    s1_abs_a, s1_abs_b;
    amb_mode_e        s1_mode;
    logic [MW-1:0]    s1_lim_lo, s1_lim_hi;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_sat;

    fix_abs_sat #(.WIDTH(WIDTH)) u_abs_a (
        .x     (in_a),
        .mag_c (abs_a_c),
        .sat_c (sat_a_c)
    );

    fix_abs_sat #(.WIDTH(WIDTH)) u_abs_b (
        .x     (in_b),
        .mag_c (abs_b_c),
        .sat_c (sat_b_c)
    );

    // S1 register: capture absolute values and sideband on acceptance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_abs_a  <= '0;
            s1_abs_b  <= '0;
            s1_mode   <= AMB_HALF;
            s1_lim_lo <= '0;
            s1_lim_hi <= '0;
            s1_tag    <= '0;
            s1_sat    <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_abs_a  <= abs_a_c;
                s1_abs_b  <= abs_b_c;
                s1_mode   <= amb_mode_e'(in_mode);
                s1_lim_lo <= in_lim_lo;
                s1_lim_hi <= in_lim_hi;
                s1_tag    <= in_tag;
                s1_sat    <= sat_a_c || sat_b_c;
            end
        end
    end

    // ---------------------------------------------------------------- S2
    logic             a_ge_b_c;
    logic [MW-1:0]    s2_max, s2_min;
    amb_mode_e        s2_mode;
    logic [MW-1:0]    s2_lim_lo, s2_lim_hi;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_sat;

    // Ties keep |a| as the major component.
    assign a_ge_b_c = (s1_abs_a >= s1_abs_b);

    // S2 register: sort the magnitudes into major/minor.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_valid  <= 1'b0;
            s2_max    <= '0;
            s2_min    <= '0;
            s2_mode   <= AMB_HALF;
            s2_lim_lo <= '0;
            s2_lim_hi <= '0;
            s2_tag    <= '0;
            s2_sat    <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_max    <= a_ge_b_c ? s1_abs_a : s1_abs_b;
                s2_min    <= a_ge_b_c ? s1_abs_b : s1_abs_a;
                s2_mode   <= s1_mode;
                s2_lim_lo <= s1_lim_lo;
                s2_lim_hi <= s1_lim_hi;
                s2_tag    <= s1_tag;
                s2_sat    <= s1_sat;
            end
        end
    end

    // ---------------------------------------------------------------- S3
    logic [SW-1:0] big_c, small_c, sum_c, alt_c;
    logic          ovf_c;
    logic [MW-1:0] mag_c;
    logic          slow_c, fast_c;

    assign big_c   = SW'(s2_max);
    assign small_c = SW'(s2_min);

    // Combine major/minor per mode; all shifts are on non-negative values.
    always_comb begin
        sum_c = big_c;
        alt_c = '0;
        case (s2_mode)
            AMB_HALF:    sum_c = big_c + (small_c >> 1);
            AMB_QUARTER: sum_c = big_c + (small_c >> 2);
            AMB_15_16:   sum_c = (big_c - (big_c >> 4)) +
                                 ((small_c >> 1) - (small_c >> 5));
            AMB_MAX78: begin
                alt_c = (big_c - (big_c >> 3)) + (small_c >> 1);
                sum_c = (alt_c > big_c) ? alt_c : big_c;
            end
            default:     sum_c = big_c;
        endcase
    end

    // Clamp to the largest positive word and compare against the limits.
    assign ovf_c  = (sum_c > SW'(MAG_MAX));
    assign mag_c  = ovf_c ? MAG_MAX : MW'(sum_c);
    assign slow_c = (mag_c < s2_lim_lo);
    assign fast_c = (mag_c > s2_lim_hi);

    // S3 register: drives the output port directly; holds under backpressure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_tag   <= '0;
            out_slow  <= 1'b0;
            out_fast  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (s3_en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_mag  <= {1'b0, mag_c};
                out_tag  <= s2_tag;
                out_slow <= slow_c;
                out_fast <= fast_c;
                out_sat  <= ovf_c || s2_sat;
            end
        end
    end

endmodule : amax_bmin_pipe
